fifo_rdch_scheduler: RTL and testbench

- Command sequencer for the multichannel FIFO read controller.
- Watches per-channel fill levels and the free space in the downstream single-channel CDC FIFO.
- Chooses channels round-robin and issues one read command (channel select plus read count) at a time.
- Waits for each command to be accepted and completed before the next, so no command is ever overridden mid-transfer.

---
 rtl/fifo_rdch_scheduler_if.sv | 37 +++
 rtl/fifo_rdch_scheduler.sv | 160 ++++++++++++++++
 tb/tb_fifo_rdch_scheduler.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rdch_scheduler_if.sv
// Command-sequencer bus between the multichannel FIFO read scheduler and its
// surroundings: fill/free status in, one-at-a-time read commands out.
interface fifo_rdch_scheduler_if #(
    parameter int RD_CHANNEL_CNT   = 5,
    parameter int RD_CHANNEL_DEPTH = 1024
);
    localparam int CW = $clog2(RD_CHANNEL_DEPTH) + 1;
    localparam int SW = (RD_CHANNEL_CNT > 1) ? $clog2(RD_CHANNEL_CNT) : 1;

    logic                         i_enable;
    logic [RD_CHANNEL_CNT-1:0]    i_ch_mask;
    logic [RD_CHANNEL_CNT*CW-1:0] i_ch_fill;
    logic [CW-1:0]                i_dst_free;
    logic                         i_cmd_ready;

    logic                         o_cmd_valid;
    logic [SW-1:0]                o_cmd_rdchsel;
    logic [CW-1:0]                o_cmd_rdcnt;
    logic                         o_busy;
    logic [SW-1:0]                o_last_ch;
    logic [31:0]                  o_cmd_count;
    logic                         o_timeout_err;

    // scheduler side
    modport master (
        input  i_enable, i_ch_mask, i_ch_fill, i_dst_free, i_cmd_ready,
        output o_cmd_valid, o_cmd_rdchsel, o_cmd_rdcnt, o_busy, o_last_ch,
               o_cmd_count, o_timeout_err
    );

    // status provider / read controller side
    modport slave (
        output i_enable, i_ch_mask, i_ch_fill, i_dst_free, i_cmd_ready,
        input  o_cmd_valid, o_cmd_rdchsel, o_cmd_rdcnt, o_busy, o_last_ch,
               o_cmd_count, o_timeout_err
    );
endinterface

// File: rtl/fifo_rdch_scheduler.sv
// Round-robin read-command sequencer for the multichannel FIFO: one command in
// flight at a time, each sized to what the channel holds and downstream accepts.

// Per-channel eligibility and fill clamp.
module fifo_rdch_lane #(
    parameter int CW    = 11,
    parameter int DEPTH = 1024
) (
    input  logic          mask,
    input  logic [CW-1:0] fill,
    output logic          elig,
    output logic [CW-1:0] fill_clamped
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    assign fill_clamped = (fill > DEPTH_C) ? DEPTH_C : fill;
    assign elig         = mask && (fill != '0);
endmodule

module fifo_rdch_scheduler #(
    parameter int RD_CHANNEL_CNT   = 5,
    parameter int RD_CHANNEL_DEPTH = 1024,
    parameter int MAX_BURST        = 256,
    parameter int ACK_TIMEOUT      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_rdch_scheduler_if.master  bus
);
    localparam int N  = RD_CHANNEL_CNT;
    localparam int CW = $clog2(RD_CHANNEL_DEPTH) + 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1) + 1;

    localparam logic [CW-1:0] MB_C   = CW'(MAX_BURST);
    localparam logic [TW-1:0] TO_LIM = TW'(ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_C = SW'(N - 1);

    typedef enum logic [1:0] {SCAN, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        elig;
    logic [N-1:0][CW-1:0] fill_c;
    logic [SW-1:0]       rr_q;
    logic [SW-1:0]       sel_q, sel_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       last_q;
    logic [31:0]         count_q;
    logic                err_q;
    logic [TW-1:0]       to_q, to_next;
    logic                to_hit;
    logic                decide;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            fifo_rdch_lane #(.CW(CW), .DEPTH(RD_CHANNEL_DEPTH)) u_lane (
                .mask         (bus.i_ch_mask[k]),
                .fill         (bus.i_ch_fill[k*CW +: CW]),
                .elig         (elig[k]),
                .fill_clamped (fill_c[k])
            );
        end
    endgenerate

    // Rotating priority: walk offsets high to low so the nearest one to rr wins.
    logic [SW:0] j;
    always_comb begin
        sel_d = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = {1'b0, rr_q} + (SW+1)'(i);
            if (j >= (SW+1)'(N))
                j = j - (SW+1)'(N);
            if (elig[j[SW-1:0]])
                sel_d = j[SW-1:0];
        end
    end

    logic [CW-1:0] f_sel, burst;
    always_comb begin
        f_sel = fill_c[sel_d];
        burst = (f_sel > MB_C) ? MB_C : f_sel;
        cnt_d = (burst > bus.i_dst_free) ? bus.i_dst_free : burst;
    end

    assign decide  = bus.i_enable && bus.i_cmd_ready && (bus.i_dst_free != '0) && (|elig);
    assign to_next = to_q + TW'(1);
    // The incremented count reaching the limit ends the wait, so ACK_TIMEOUT=4
    // gives three ready-high WAIT_ACK cycles before falling back to SCAN.
    assign to_hit  = (to_next >= TO_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= SCAN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:      if (decide) state_d = ISSUE;
            ISSUE:     state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (!bus.i_cmd_ready)
                    state_d = WAIT_DONE;
                else if (to_hit)
                    state_d = SCAN;
            end
            WAIT_DONE: if (bus.i_cmd_ready) state_d = SCAN;
            default:   state_d = SCAN;
        endcase
    end

    // sel/cnt are latched at the decision edge, so they appear with the strobe
    // and hold until the next decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            last_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (decide) begin
                        sel_q <= sel_d;
                        cnt_q <= cnt_d;
                    end
                end
                ISSUE: begin
                    count_q <= count_q + 32'd1;
                    last_q  <= sel_q;
                    rr_q    <= (sel_q == LAST_C) ? '0 : sel_q + SW'(1);
                    to_q    <= '0;
                end
                WAIT_ACK: begin
                    if (bus.i_cmd_ready) begin
                        to_q <= to_next;
                        if (to_hit)
                            err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_cmd_valid   = (state_q == ISSUE);
    assign bus.o_cmd_rdchsel = sel_q;
    assign bus.o_cmd_rdcnt   = cnt_q;
    assign bus.o_busy        = (state_q != SCAN);
    assign bus.o_last_ch     = last_q;
    assign bus.o_cmd_count   = count_q;
    assign bus.o_timeout_err = err_q;
endmodule

// File: tb/tb_fifo_rdch_scheduler.sv
// Directed bench for fifo_rdch_scheduler with a transaction-level round-robin
// model checked every cycle, plus literal expectations per scenario.
module tb_fifo_rdch_scheduler;
    localparam int N     = 5;
    localparam int DEPTH = 1024;
    localparam int CW    = 11;
    localparam int SW    = 3;
    localparam int MB    = 256;
    localparam int AT    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          enable = 1'b0;
    logic [N-1:0]  mask = '0;
    logic [CW-1:0] fill [N];
    logic [CW-1:0] free = '0;
    logic          man_ready = 1'b1;
    logic          resp_on = 1'b1;
    logic          resp_ready = 1'b1;
    logic [N*CW-1:0] fill_flat;

    int tests = 0;
    int fails = 0;

    fifo_rdch_scheduler_if #(.RD_CHANNEL_CNT(N), .RD_CHANNEL_DEPTH(DEPTH)) bus ();

    fifo_rdch_scheduler #(
        .RD_CHANNEL_CNT(N), .RD_CHANNEL_DEPTH(DEPTH), .MAX_BURST(MB), .ACK_TIMEOUT(AT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always_comb begin
        fill_flat = '0;
        for (int k = 0; k < N; k++) fill_flat[k*CW +: CW] = fill[k];
    end

    assign bus.i_enable    = enable;
    assign bus.i_ch_mask   = mask;
    assign bus.i_ch_fill   = fill_flat;
    assign bus.i_dst_free  = free;
    assign bus.i_cmd_ready = resp_on ? resp_ready : man_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Controller stand-in: drops ready the cycle after a strobe, raises it 12 cycles later.
    logic v_seen = 1'b0;
    int   hold = 0;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            hold = 0;
            resp_ready = 1'b1;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) resp_ready = 1'b1;
        end else if (v_seen) begin
            resp_ready = 1'b0;
            hold = 12;
        end
    end

    // Transaction model: next grant is the first eligible channel at or after
    // the channel following the last grant; size is min(fill, burst, free).
    int            cyc = 0;
    int            m_rr = 0, m_last = 0, pend_sel = 0, last_v = -100, n_valid = 0;
    logic [31:0]   m_count = 0;
    bit            pend = 0, s_ok = 0;
    logic          s_en, s_ready, s_busy;
    logic [N-1:0]  s_mask;
    logic [CW-1:0] s_fill [N];
    logic [CW-1:0] s_free;
    bit            e_ok;
    int            e_sel, e_cnt, fk;

    always @(negedge clk) begin
        cyc++;
        v_seen = bus.o_cmd_valid;
        if (!rst) begin
            m_rr = 0; m_last = 0; m_count = 0; pend = 0; s_ok = 0; last_v = -100;
        end else begin
            if (pend) begin
                m_count++;
                m_last = pend_sel;
                m_rr = (pend_sel + 1) % N;
                pend = 0;
            end
            chk("model_cmd_count", bus.o_cmd_count, m_count);
            chk("model_last_ch", 32'(bus.o_last_ch), 32'(m_last));
            if (s_ok) begin
                e_ok = 0; e_sel = 0; e_cnt = 0;
                for (int off = 0; off < N; off++) begin
                    fk = (m_rr + off) % N;
                    if (!e_ok && s_mask[fk] && s_fill[fk] != 0) begin
                        e_ok = 1;
                        e_sel = fk;
                    end
                end
                if (e_ok) begin
                    e_cnt = (int'(s_fill[e_sel]) > DEPTH) ? DEPTH : int'(s_fill[e_sel]);
                    if (e_cnt > MB) e_cnt = MB;
                    if (e_cnt > int'(s_free)) e_cnt = int'(s_free);
                end
                e_ok = e_ok && s_en && s_ready && (s_free != 0) && !s_busy;
                if (bus.o_cmd_valid || e_ok)
                    chk("model_issue", 32'(bus.o_cmd_valid), 32'(e_ok));
                if (bus.o_cmd_valid) begin
                    chk("model_rdchsel", 32'(bus.o_cmd_rdchsel), 32'(e_sel));
                    chk("model_rdcnt", 32'(bus.o_cmd_rdcnt), 32'(e_cnt));
                    chk("model_busy_on_issue", 32'(bus.o_busy), 32'd1);
                    chk("model_spacing_ok", 32'(cyc - last_v >= 4), 32'd1);
                    pend = 1;
                    pend_sel = e_sel;
                    last_v = cyc;
                    n_valid++;
                end
            end
            s_en = enable; s_ready = bus.i_cmd_ready; s_busy = bus.o_busy;
            s_mask = mask; s_free = free;
            for (int k = 0; k < N; k++) s_fill[k] = fill[k];
            s_ok = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget,
                              output int sel, output int cnt);
        bit got = 0;
        sel = -1; cnt = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.o_cmd_valid) begin
                got = 1;
                sel = int'(bus.o_cmd_rdchsel);
                cnt = int'(bus.o_cmd_rdcnt);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s: no command strobe within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int sel, cnt, nv0;
    int rr_exp [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        for (int k = 0; k < N; k++) fill[k] = '0;
        tick(3);
        @(negedge clk);
        chk("reset_valid", 32'(bus.o_cmd_valid), 0);
        chk("reset_busy", 32'(bus.o_busy), 0);
        chk("reset_count", bus.o_cmd_count, 0);
        chk("reset_last", 32'(bus.o_last_ch), 0);
        chk("reset_err", 32'(bus.o_timeout_err), 0);
        chk("reset_rdchsel", 32'(bus.o_cmd_rdchsel), 0);
        chk("reset_rdcnt", 32'(bus.o_cmd_rdcnt), 0);
        tick(1);
        rst = 1'b1;
        tick(2);

        // single channel
        nv0 = n_valid;
        mask = 5'b00100; fill[2] = 10; free = 100; enable = 1'b1;
        wait_valid("single_wait", 20, sel, cnt);
        chk("single_sel", 32'(sel), 2);
        chk("single_cnt", 32'(cnt), 10);
        tick(1);
        mask = '0;
        tick(30);
        @(negedge clk);
        chk("single_count", bus.o_cmd_count, 1);
        chk("single_pulses", 32'(n_valid - nv0), 1);
        chk("single_idle", 32'(bus.o_busy), 0);
        tick(1);

        // burst clamp, then free-space clamp
        fill[2] = 0; fill[0] = 600; free = 1000; mask = 5'b00001;
        wait_valid("clamp_burst_wait", 20, sel, cnt);
        chk("clamp_burst_cnt", 32'(cnt), 256);
        tick(1);
        mask = '0;
        tick(25);
        free = 40; mask = 5'b00001;
        wait_valid("clamp_free_wait", 20, sel, cnt);
        chk("clamp_free_cnt", 32'(cnt), 40);
        tick(1);
        mask = '0;
        tick(4);
        @(negedge clk);
        chk("pre_reset_count", bus.o_cmd_count, 3);
        chk("pre_reset_busy", 32'(bus.o_busy), 1);

        // asynchronous reset mid-WAIT_DONE
        tick(1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.o_cmd_valid), 0);
        chk("async_rst_count", bus.o_cmd_count, 0);
        chk("async_rst_busy", 32'(bus.o_busy), 0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // no downstream space
        nv0 = n_valid;
        free = 0; mask = 5'b00001;
        tick(20);
        @(negedge clk);
        chk("free0_pulses", 32'(n_valid - nv0), 0);
        chk("free0_count", bus.o_cmd_count, 0);
        tick(1);
        mask = '0; fill[0] = 0;

        // round-robin over all channels
        for (int k = 0; k < N; k++) fill[k] = 8;
        free = 100; mask = 5'b11111;
        for (int r = 0; r < 6; r++) begin
            wait_valid("rr_wait", 40, sel, cnt);
            chk("rr_sel", 32'(sel), 32'(rr_exp[r]));
            chk("rr_cnt", 32'(cnt), 8);
            @(negedge clk);
            chk("rr_last_ch", 32'(bus.o_last_ch), 32'(rr_exp[r]));
        end
        tick(1);
        mask = '0;
        tick(20);

        // acknowledge timeout
        resp_on = 1'b0; man_ready = 1'b1;
        for (int k = 0; k < N; k++) fill[k] = 0;
        fill[1] = 5; mask = 5'b00010;
        wait_valid("to_wait", 20, sel, cnt);
        chk("to_sel", 32'(sel), 1);
        chk("to_cnt", 32'(cnt), 5);
        chk("to_err_at_issue", 32'(bus.o_timeout_err), 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("to_err_timing", 32'(bus.o_timeout_err), (c == 4) ? 1 : 0);
        end
        chk("to_back_to_scan", 32'(bus.o_busy), 0);
        @(negedge clk);
        chk("to_reissue_valid", 32'(bus.o_cmd_valid), 1);
        chk("to_reissue_sel", 32'(bus.o_cmd_rdchsel), 1);
        tick(1);
        mask = '0;
        tick(10);
        @(negedge clk);
        chk("to_err_sticky", 32'(bus.o_timeout_err), 1);
        tick(1);

        // enable dropped mid-command
        resp_on = 1'b1;
        fill[1] = 0; fill[3] = 4; mask = 5'b01000;
        wait_valid("en_wait", 20, sel, cnt);
        chk("en_sel", 32'(sel), 3);
        tick(4);
        enable = 1'b0;
        nv0 = n_valid;
        tick(30);
        @(negedge clk);
        chk("en_off_pulses", 32'(n_valid - nv0), 0);
        chk("en_off_idle", 32'(bus.o_busy), 0);
        chk("en_hold_rdchsel", 32'(bus.o_cmd_rdchsel), 3);
        chk("en_hold_rdcnt", 32'(bus.o_cmd_rdcnt), 4);
        tick(1);
        enable = 1'b1;
        wait_valid("en_resume_wait", 10, sel, cnt);
        chk("en_resume_sel", 32'(sel), 3);
        tick(1);
        mask = '0;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
